// File: rtl/multiword_add_sequencer_if.sv
// Handshake and Add-unit bus for multiword_add_sequencer.
// The sequencer uses the slave view; requester, consumer and the Add unit share the master view.
interface multiword_add_sequencer_if #(
   parameter int unsigned N = 32,
   parameter int unsigned W = 4
);
   localparam int unsigned WN = N * W;

   logic          in_valid;
   logic          in_ready;
   logic [WN-1:0] in_a;
   logic [WN-1:0] in_b;
   logic          in_ci;
   logic          in_sub;

   logic [N-1:0]  add_a;
   logic [N-1:0]  add_b;
   logic          add_ci;
   logic [N-1:0]  add_c;
   logic          add_co;

   logic          out_valid;
   logic          out_ready;
   logic [WN-1:0] out_c;
   logic          out_co;
   logic          out_ovf;

   modport slave (
      input  in_valid, in_a, in_b, in_ci, in_sub,
      output in_ready,
      output add_a, add_b, add_ci,
      input  add_c, add_co,
      output out_valid, out_c, out_co, out_ovf,
      input  out_ready
   );

   modport master (
      output in_valid, in_a, in_b, in_ci, in_sub,
      input  in_ready,
      input  add_a, add_b, add_ci,
      output add_c, add_co,
      input  out_valid, out_c, out_co, out_ovf,
      output out_ready
   );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams W slices of N bits, LSB first,
// through an external N-bit Add unit and assembles the W*N-bit result.
module multiword_add_sequencer #(
   parameter int unsigned N = 32,
   parameter int unsigned W = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   multiword_add_sequencer_if.slave bus
);
   localparam int unsigned WN = N * W;
   localparam int unsigned KW = (W > 1) ? $clog2(W) : 1;
   localparam logic [KW-1:0] KLAST = KW'(W - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state;
   logic [KW-1:0] k;
   logic          carry;
   logic [WN-1:0] a_r;
   logic [WN-1:0] b_r;
   logic [WN-1:0] res;
   logic          co_r;
   logic          ovf_r;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         k     <= '0;
         carry <= 1'b0;
         res   <= '0;
         co_r  <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  // Subtraction as A + ~B + 1; B is inverted once here so RUN is add-only.
                  a_r   <= bus.in_a;
                  b_r   <= bus.in_sub ? ~bus.in_b : bus.in_b;
                  carry <= bus.in_sub ? 1'b1 : bus.in_ci;
                  k     <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               res[k*N +: N] <= bus.add_c;
               carry         <= bus.add_co;
               if (k == KLAST) begin
                  co_r  <= bus.add_co;
                  ovf_r <= (a_r[WN-1] == b_r[WN-1]) && (bus.add_c[N-1] != a_r[WN-1]);
                  k     <= '0;
                  state <= S_DONE;
               end else begin
                  k <= k + KW'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.add_a  = '0;
      bus.add_b  = '0;
      bus.add_ci = 1'b0;
      if (state == S_RUN) begin
         bus.add_a  = a_r[k*N +: N];
         bus.add_b  = b_r[k*N +: N];
         bus.add_ci = carry;
      end
   end

   assign bus.in_ready  = rst_n && (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_c     = res;
   assign bus.out_co    = co_r;
   assign bus.out_ovf   = ovf_r;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_multiword_add_sequencer;
   localparam int unsigned N  = 32;
   localparam int unsigned W  = 4;
   localparam int unsigned WN = N * W;

   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   multiword_add_sequencer_if #(.N(N), .W(W)) bus ();

   multiword_add_sequencer #(.N(N), .W(W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // External Add unit: plain combinational N-bit adder.
   always_comb begin
      {bus.add_co, bus.add_c} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + (N+1)'(bus.add_ci);
   end

   typedef struct {
      logic [WN-1:0] a;
      logic [WN-1:0] b;
      logic          ci;
      logic          sub;
      logic [WN-1:0] c;
      logic          co;
      logic          ovf;
      logic [W-1:0]  cis;
   } vec_t;

   task automatic chk(input string nm, input logic [WN-1:0] act, input logic [WN-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   // Reference: integer arithmetic on the whole operands; carries into each slice
   // come from comparing/adding the low-order prefixes below that slice.
   function automatic void ref_op(input logic [WN-1:0] a, b, input logic ci, sub,
                                  output logic [WN-1:0] c, output logic co, ovf,
                                  output logic [W-1:0] cis);
      logic [WN:0] ua, ub, sum, mask;
      logic signed [WN+1:0] sa, sb, st;
      ua = {1'b0, a};
      ub = {1'b0, b};
      sa = $signed(a);
      sb = $signed(b);
      if (sub) begin
         sum = ua - ub;
         co  = (a >= b);
         st  = sa - sb;
      end else begin
         sum = ua + ub + (WN+1)'(ci);
         co  = sum[WN];
         st  = sa + sb + (WN+2)'(ci);
      end
      c   = sum[WN-1:0];
      ovf = (st[WN+1:WN-1] != {3{st[WN-1]}});
      for (int k = 0; k < int'(W); k++) begin
         mask = ((WN+1)'(1) << (k * N)) - 1;
         if (sub) cis[k] = ((ua & mask) >= (ub & mask));
         else     cis[k] = ((((ua & mask) + (ub & mask) + (WN+1)'(ci)) >> (k * N)) != 0);
      end
   endfunction

   task automatic do_op(input logic [WN-1:0] a, b, input logic ci, sub, input bit release_it,
                        output logic [WN-1:0] c, output logic co, ovf,
                        output int lat, output logic [W-1:0] cis);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("in_ready_before_accept", WN'(bus.in_ready), WN'(1));
      bus.in_a = a; bus.in_b = b; bus.in_ci = ci; bus.in_sub = sub; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble operands after accept: they must have been captured already.
      bus.in_valid = 1'b0;
      bus.in_a = {$urandom, $urandom, $urandom, $urandom};
      bus.in_b = {$urandom, $urandom, $urandom, $urandom};
      bus.in_ci = 1'($urandom);
      bus.in_sub = 1'($urandom);
      cis = '0;
      lat = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.out_valid) break;
         if (lat < int'(W)) cis[lat] = bus.add_ci;
         lat++;
      end
      c = bus.out_c; co = bus.out_co; ovf = bus.out_ovf;
      if (release_it) begin
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end
   endtask

   vec_t          vecs[7];
   logic [WN-1:0] c, ec, held, r0, r1, e0, e1;
   logic [WN-1:0] ones, msb;
   logic          co, ovf, eco, eovf;
   logic [W-1:0]  cis, ecis;
   int            lat, nacc, nres, acc_t[2];
   bit            seen;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      ones = '1;
      msb  = '0; msb[WN-1] = 1'b1;
      //            a              b         ci    sub   c            co    ovf   cis (bit k = slice k)
      vecs[0] = '{ones,          WN'(1),     1'b0, 1'b0, '0,          1'b1, 1'b0, 4'b1110};
      vecs[1] = '{WN'(5),        WN'(7),     1'b1, 1'b1, ~WN'(1),     1'b0, 1'b0, 4'b0001};
      vecs[2] = '{~msb,          WN'(1),     1'b0, 1'b0, msb,         1'b0, 1'b1, 4'b1110};
      vecs[3] = '{msb,           WN'(1),     1'b0, 1'b1, ~msb,        1'b1, 1'b1, 4'b0001};
      vecs[4] = '{'0,            '0,         1'b1, 1'b0, WN'(1),      1'b0, 1'b0, 4'b0001};
      vecs[5] = '{WN'(16'h1234), WN'(16'h1234), 1'b0, 1'b1, '0,       1'b1, 1'b0, 4'b1111};
      vecs[6] = '{WN'(32'hFFFF_FFFF), WN'(1), 1'b0, 1'b0, WN'(64'h1_0000_0000), 1'b0, 1'b0, 4'b0010};

      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.in_a = '0; bus.in_b = '0; bus.in_ci = 1'b0; bus.in_sub = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", WN'(bus.in_ready), '0);
      chk("rst_out_valid", WN'(bus.out_valid), '0);
      chk("rst_out_c", bus.out_c, '0);
      chk("rst_out_co", WN'(bus.out_co), '0);
      chk("rst_out_ovf", WN'(bus.out_ovf), '0);
      chk("rst_add_a", WN'(bus.add_a), '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", WN'(bus.in_ready), WN'(1));

      foreach (vecs[i]) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, 1'b1, c, co, ovf, lat, cis);
         chk($sformatf("vec%0d_c", i), c, vecs[i].c);
         chk($sformatf("vec%0d_co", i), WN'(co), WN'(vecs[i].co));
         chk($sformatf("vec%0d_ovf", i), WN'(ovf), WN'(vecs[i].ovf));
         chk($sformatf("vec%0d_latency", i), WN'(lat), WN'(W));
         chk($sformatf("vec%0d_slice_ci", i), WN'(cis), WN'(vecs[i].cis));
      end

      // Backpressure: result held for 10 cycles with out_ready low.
      do_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
            1'b1, 1'b0, 1'b0, c, co, ovf, lat, cis);
      ref_op(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
             1'b1, 1'b0, ec, eco, eovf, ecis);
      chk("bp_c", c, ec);
      held = c;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_valid", WN'(bus.out_valid), WN'(1));
         chk("bp_out_c_stable", bus.out_c, held);
         chk("bp_in_ready", WN'(bus.in_ready), '0);
         chk("bp_add_bus_idle", WN'({bus.add_a, bus.add_b, bus.add_ci}), '0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("bp_release_in_ready", WN'(bus.in_ready), WN'(1));
      chk("bp_release_out_valid", WN'(bus.out_valid), '0);

      // Back-to-back requests with in_valid and out_ready held high.
      ref_op(WN'(100), WN'(200), 1'b0, 1'b0, e0, eco, eovf, ecis);
      ref_op(WN'(1000), WN'(1), 1'b0, 1'b1, e1, eco, eovf, ecis);
      @(posedge clk); #1;
      bus.in_a = WN'(100); bus.in_b = WN'(200); bus.in_ci = 1'b0; bus.in_sub = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      nacc = 0; nres = 0; acc_t[0] = 0; acc_t[1] = 0; r0 = '0; r1 = '0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (nres == 0) r0 = bus.out_c;
            else if (nres == 1) r1 = bus.out_c;
            nres++;
         end
         if (bus.in_valid && bus.in_ready && nacc < 2) begin
            acc_t[nacc] = i;
            nacc++;
         end
         @(posedge clk); #1;
         if (nacc == 1) begin
            bus.in_a = WN'(1000); bus.in_b = WN'(1); bus.in_sub = 1'b1;
         end
         if (nacc == 2) bus.in_valid = 1'b0;
         if (nres >= 2) break;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      chk("b2b_accepts", WN'(nacc), WN'(2));
      chk("b2b_spacing", WN'(acc_t[1] - acc_t[0]), WN'(W + 2));
      chk("b2b_result0", r0, e0);
      chk("b2b_result1", r1, e1);

      // Reset in the middle of RUN (during slice 2).
      @(negedge clk);
      bus.in_a = {4{32'h1111_1111}}; bus.in_b = {4{32'h2222_2222}}; bus.in_ci = 1'b0; bus.in_sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready_low", WN'(bus.in_ready), '0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_out_c", bus.out_c, '0);
      chk("midrst_out_co_ovf", WN'({bus.out_co, bus.out_ovf}), '0);
      chk("midrst_out_valid", WN'(bus.out_valid), '0);
      chk("midrst_add_bus_idle", WN'({bus.add_a, bus.add_b, bus.add_ci}), '0);
      chk("midrst_in_ready", WN'(bus.in_ready), WN'(1));
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.out_valid) seen = 1'b1;
      end
      chk("midrst_no_out_valid", WN'(seen), '0);
      do_op(WN'(3), WN'(4), 1'b0, 1'b0, 1'b1, c, co, ovf, lat, cis);
      chk("post_rst_c", c, WN'(7));
      chk("post_rst_latency", WN'(lat), WN'(W));

      // Randomized operations with random consumer delay.
      for (int t = 0; t < 40; t++) begin
         logic [WN-1:0] ra, rb;
         logic rci, rsub;
         int d;
         ra = {$urandom, $urandom, $urandom, $urandom};
         rb = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 3))
            0: ;
            1: rb = ~ra;
            2: rb = ra;
            default: begin ra[WN-1] = ~rb[WN-1]; ra[N-1:0] = '1; end
         endcase
         rci = 1'($urandom);
         rsub = 1'($urandom);
         ref_op(ra, rb, rci, rsub, ec, eco, eovf, ecis);
         do_op(ra, rb, rci, rsub, 1'b0, c, co, ovf, lat, cis);
         chk($sformatf("rnd%0d_c", t), c, ec);
         chk($sformatf("rnd%0d_co", t), WN'(co), WN'(eco));
         chk($sformatf("rnd%0d_ovf", t), WN'(ovf), WN'(eovf));
         chk($sformatf("rnd%0d_latency", t), WN'(lat), WN'(W));
         chk($sformatf("rnd%0d_slice_ci", t), WN'(cis), WN'(ecis));
         d = $urandom_range(0, 3);
         repeat (d) @(negedge clk);
         chk($sformatf("rnd%0d_hold", t), bus.out_c, ec);
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequential multi-precision add/subtract controller for the FixedPointArithmetic IP. It accepts W·N-bit operands over a valid/ready handshake and streams them one N-bit slice per cycle, LSB slice first, into an external N-bit Add unit (any Add model, e.g. the carry-lookahead variant). It consumes the unit's sum and carry-out, ripples the carry between slices, and presents the assembled W·N-bit result on a valid/ready output.

## Interface
- N, 32, slice width; must match the attached Add unit's datapath width
- W, 4, slices per operand; W ≥ 2; total width WN = N·W
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operation request
- in_ready  output  1  sequencer can accept a request
- in_a  input  WN  operand A
- in_b  input  WN  operand B
- in_ci  input  1  carry in (add only)
- in_sub  input  1  1 = A − B, 0 = A + B + ci
- add_a  output  N  slice of A to Add unit
- add_b  output  N  slice of effective B to Add unit
- add_ci  output  1  carry into Add unit
- add_c  input  N  Add unit sum (combinational from add_a/add_b/add_ci)
- add_co  input  1  Add unit carry out
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_c  output  WN  result
- out_co  output  1  carry out of MSB slice (sub: 1 = no borrow)
- out_ovf  output  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready: register A; register B_eff = in_sub ? ~in_b : in_b; carry register = in_sub ? 1 : in_ci; slice index k = 0; go RUN.
- RUN: add_a = A[k·N +: N], add_b = B_eff[k·N +: N], add_ci = carry register. Each edge: out_c[k·N +: N] ← add_c; carry ← add_co; k ← k+1. Edge capturing k = W−1 also loads out_co ← add_co, computes out_ovf, goes DONE.
- out_ovf = (A[WN−1] == B_eff[WN−1]) && (result[WN−1] != A[WN−1]), using the final captured MSB slice.
- DONE: out_valid = 1; out_c, out_co, out_ovf held stable. On out_valid && out_ready go IDLE.
- in_ci ignored when in_sub = 1. All arithmetic modulo 2^WN.
- add_a, add_b, add_ci driven 0 outside RUN.
- in_ready = 0 in RUN and DONE; no request accepted while a result is pending.
- Reset (rst_n low at an edge): state IDLE, k = 0, carry = 0, out_c = 0, out_co = 0, out_ovf = 0, out_valid = 0. in_ready forced 0 in any cycle where rst_n is low. Reset during RUN or DONE abandons the operation; no out_valid follows.

## Timing
- Accept edge E0. Slice k is presented to the Add unit during the cycle after edge Ek and captured at edge Ek+1.
- out_valid rises after edge EW, i.e. W cycles after accept. The default is 4.
- The result handshake edge returns the FSM to IDLE. in_ready is high in the following cycle.
- Minimum request spacing: W+2 cycles.
- The Add unit path (add_a → add_c/add_co) is combinational within one cycle. It is the critical path and has no internal pipelining.
- in_a/in_b/in_sub/in_ci are sampled only on the accept edge. Changes afterwards have no effect.

## Test plan
- Carry ripple: add, A = 2^128−1, B = 1, ci = 0 (N=32, W=4) → out_c = 0, out_co = 1, out_ovf = 0, out_valid exactly 4 cycles after accept; add_ci = 1 during slices 1–3.
- Subtract with borrow: A = 5, B = 7, sub = 1, ci = 1 → out_c = 2^128−2 (0xFFFF…FFFE), out_co = 0, out_ovf = 0; add_ci = 1 during slice 0.
- Signed overflow: add, A = 0x7FFF…FFFF, B = 1 → out_c = 0x8000…0000, out_ovf = 1, out_co = 0; sub, A = 0x8000…0000, B = 1 → out_c = 0x7FFF…FFFF, out_ovf = 1.
- Carry in: add, A = B = 0, ci = 1 → out_c = 1. Sub, A = B = 0x1234, ci = 0 → out_c = 0, out_co = 1.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → out_valid stays 1, out_c stable, in_ready = 0, add_* = 0. Raise out_ready → IDLE next cycle. A back-to-back request completes with the correct result; spacing is W+2.
- Reset mid-RUN: assert rst_n = 0 for one edge at slice 2 → all outputs take reset values, no out_valid. A subsequent A = 3, B = 4 add returns 7 with correct latency.
